ttt_game_ctrl: RTL

//  Tic-tac-toe game controller that sits directly upstream of the dot-matrix display stage.

---
 rtl/ttt_game_ctrl_if.sv | 21 ++
 rtl/ttt_game_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl_if.sv
// rtl/ttt_game_ctrl_if.sv - keypad-in / board-out bundle of the tic-tac-toe controller
interface ttt_game_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [1:0]  winner;
  logic        game_over;
  logic [3:0]  move_cnt;
  logic        err;

  modport master (
    output key_valid, key_code,
    input  board, turn, winner, game_over, move_cnt, err
  );

  modport slave (
    input  key_valid, key_code,
    output board, turn, winner, game_over, move_cnt, err
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe controller: press detect, lockout, mark placement, 8-cycle line scan
module ttt_game_ctrl #(
  parameter int FIRST_PLAYER = 1,
  parameter int LOCKOUT      = 16
) (
  input  logic          freq,
  input  logic          rst,
  ttt_game_ctrl_if.slave bus
);

  localparam int          LW        = $clog2(LOCKOUT + 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);
  localparam logic [1:0]  FP        = 2'(FIRST_PLAYER);

  typedef enum logic [1:0] {S_WAIT, S_CHECK, S_OVER} state_t;

  state_t        r_state;
  logic [17:0]   r_board;
  logic [1:0]    r_turn;
  logic [1:0]    r_winner;
  logic          r_game_over;
  logic [3:0]    r_move_cnt;
  logic          r_err;
  logic          r_key_valid_q;
  logic [LW-1:0] r_lock;
  logic [2:0]    r_line;
  logic          r_win;
  logic          r_done;

  logic          w_press;
  logic          w_honour;
  logic          w_new_game;
  logic          w_is_cell;
  logic [3:0]    w_idx;
  logic          w_occupied;
  logic [1:0]    w_cells [0:8];
  logic [3:0]    w_a, w_b, w_c;
  logic          w_match;

  assign w_press    = bus.key_valid & ~r_key_valid_q;
  assign w_honour   = w_press && (r_lock == '0);
  assign w_new_game = w_honour && (bus.key_code == 4'd0);
  assign w_is_cell  = (bus.key_code >= 4'd1) && (bus.key_code <= 4'd9);
  assign w_idx      = w_is_cell ? (bus.key_code - 4'd1) : 4'd0;

  always_comb begin
    for (int i = 0; i < 9; i++) w_cells[i] = r_board[2*i +: 2];
  end

  assign w_occupied = (w_cells[w_idx] != 2'd0);

  // Cells of the line under test, 0-based row-major
  always_comb begin
    w_a = 4'd0; w_b = 4'd1; w_c = 4'd2;
    case (r_line)
      3'd0: begin w_a = 4'd0; w_b = 4'd1; w_c = 4'd2; end
      3'd1: begin w_a = 4'd3; w_b = 4'd4; w_c = 4'd5; end
      3'd2: begin w_a = 4'd6; w_b = 4'd7; w_c = 4'd8; end
      3'd3: begin w_a = 4'd0; w_b = 4'd3; w_c = 4'd6; end
      3'd4: begin w_a = 4'd1; w_b = 4'd4; w_c = 4'd7; end
      3'd5: begin w_a = 4'd2; w_b = 4'd5; w_c = 4'd8; end
      3'd6: begin w_a = 4'd0; w_b = 4'd4; w_c = 4'd8; end
      3'd7: begin w_a = 4'd2; w_b = 4'd4; w_c = 4'd6; end
      default: ;
    endcase
  end

  assign w_match = (w_cells[w_a] == r_turn) && (w_cells[w_b] == r_turn) &&
                   (w_cells[w_c] == r_turn);

  always_ff @(posedge freq) begin
    if (rst) begin
      r_state       <= S_WAIT;
      r_board       <= '0;
      r_turn        <= FP;
      r_winner      <= 2'd0;
      r_game_over   <= 1'b0;
      r_move_cnt    <= 4'd0;
      r_err         <= 1'b0;
      r_key_valid_q <= 1'b0;
      r_lock        <= '0;
      r_line        <= 3'd0;
      r_win         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_key_valid_q <= bus.key_valid;
      r_err         <= 1'b0;
      if (w_honour)
        r_lock <= LOCK_LOAD;
      else if (r_lock != '0)
        r_lock <= r_lock - LW'(1);

      if (w_new_game) begin
        r_state     <= S_WAIT;
        r_board     <= '0;
        r_turn      <= FP;
        r_winner    <= 2'd0;
        r_game_over <= 1'b0;
        r_move_cnt  <= 4'd0;
        r_line      <= 3'd0;
        r_win       <= 1'b0;
        r_done      <= 1'b0;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (w_honour && w_is_cell) begin
              if (w_occupied) begin
                r_err <= 1'b1;
              end else begin
                r_board[{w_idx, 1'b0} +: 2] <= r_turn;
                r_move_cnt <= r_move_cnt + 4'd1;
                r_state    <= S_CHECK;
                r_line     <= 3'd0;
                r_win      <= 1'b0;
                r_done     <= 1'b0;
              end
            end
          end
          S_CHECK: begin
            // Resolution happens one cycle after line 7 has been scanned
            if (r_done) begin
              if (r_win) begin
                r_winner    <= r_turn;
                r_game_over <= 1'b1;
                r_state     <= S_OVER;
              end else if (r_move_cnt == 4'd9) begin
                r_winner    <= 2'd3;
                r_game_over <= 1'b1;
                r_state     <= S_OVER;
              end else begin
                r_turn  <= (r_turn == 2'd1) ? 2'd2 : 2'd1;
                r_state <= S_WAIT;
              end
            end else begin
              if (w_match) r_win <= 1'b1;
              if (r_line == 3'd7) r_done <= 1'b1;
              r_line <= r_line + 3'd1;
            end
          end
          S_OVER: begin
            if (w_honour && w_is_cell) r_err <= 1'b1;
          end
          default: r_state <= S_WAIT;
        endcase
      end
    end
  end

  assign bus.board     = r_board;
  assign bus.turn      = r_turn;
  assign bus.winner    = r_winner;
  assign bus.game_over = r_game_over;
  assign bus.move_cnt  = r_move_cnt;
  assign bus.err       = r_err;

endmodule
